// File: rtl/exception_unit_if.sv
// Pipeline-facing signal bundle of the exception unit: trigger-stage inputs
// plus the flush/redirect controls and the architectural exception state.
interface exception_unit_if;
    logic        stageValid;
    logic [4:0]  trigger;
    logic        irq;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] dataAddress;

    logic        flush;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectAddress;
    logic [31:0] epc;
    logic [3:0]  cause;
    logic [31:0] badAddress;
    logic        interruptEnable;

    modport master (
        output stageValid, trigger, irq, eret, pc, dataAddress,
        input  flush, stall, redirect, redirectAddress, epc, cause, badAddress, interruptEnable
    );

    modport slave (
        input  stageValid, trigger, irq, eret, pc, dataAddress,
        output flush, stall, redirect, redirectAddress, epc, cause, badAddress, interruptEnable
    );
endinterface

// File: rtl/exception_unit.sv
// Precise exception/interrupt sequencer: IDLE detects an event, SAVE commits
// epc/cause/badAddress and masks interrupts, VECTOR redirects fetch to the handler.
module exception_unit #(
    parameter logic [31:0] VECTOR_BASE   = 32'h0000_0100,
    parameter int          VECTOR_STRIDE = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    exception_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2
    } state_t;

    localparam logic [3:0]  CAUSE_NONE   = 4'd0;
    localparam logic [3:0]  CAUSE_IRQ    = 4'd1;
    localparam logic [3:0]  CAUSE_BREAK  = 4'd2;
    localparam logic [3:0]  CAUSE_SYSTEM = 4'd3;
    localparam logic [3:0]  CAUSE_UNKNWN = 4'd4;
    localparam logic [3:0]  CAUSE_IALIGN = 4'd5;
    localparam logic [3:0]  CAUSE_DALIGN = 4'd6;
    localparam logic [31:0] STRIDE       = 32'(VECTOR_STRIDE);

    state_t      state_q;
    logic [3:0]  lat_cause_q;
    logic [31:0] lat_pc_q;
    logic [31:0] lat_addr_q;
    logic [31:0] epc_q;
    logic [3:0]  cause_q;
    logic [31:0] bad_addr_q;
    logic        ie_q;
    logic        saved_ie_q;

    logic        irq_req;
    logic        event_take;
    logic        eret_take;
    logic [3:0]  cause_d;
    logic [31:0] vector_addr;

    assign irq_req    = bus.irq & ie_q;
    assign event_take = (state_q == IDLE) & bus.stageValid & ((|bus.trigger) | irq_req);
    assign eret_take  = (state_q == IDLE) & bus.stageValid & bus.eret & ~event_take;

    // trigger bits: [4]=break [3]=system [2]=unknown [1]=instrAlign [0]=dataAlign
    always_comb begin
        cause_d = CAUSE_NONE;
        if (bus.trigger[1])      cause_d = CAUSE_IALIGN;
        else if (bus.trigger[2]) cause_d = CAUSE_UNKNWN;
        else if (bus.trigger[0]) cause_d = CAUSE_DALIGN;
        else if (bus.trigger[3]) cause_d = CAUSE_SYSTEM;
        else if (bus.trigger[4]) cause_d = CAUSE_BREAK;
        else if (irq_req)        cause_d = CAUSE_IRQ;
    end

    // cause_q is already committed by the time VECTOR is reached
    assign vector_addr = VECTOR_BASE + ({28'd0, cause_q} * STRIDE);

    // Pipeline controls are decoded from state so the event cycle can flush
    // combinationally; everything is held low while reset is asserted.
    always_comb begin
        bus.flush           = 1'b0;
        bus.stall           = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirectAddress = 32'd0;
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    if (event_take) begin
                        bus.flush = 1'b1;
                    end else if (eret_take) begin
                        bus.flush           = 1'b1;
                        bus.redirect        = 1'b1;
                        bus.redirectAddress = epc_q;
                    end
                end
                SAVE: begin
                    bus.flush = 1'b1;
                    bus.stall = 1'b1;
                end
                VECTOR: begin
                    bus.stall           = 1'b1;
                    bus.redirect        = 1'b1;
                    bus.redirectAddress = vector_addr;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            lat_cause_q <= CAUSE_NONE;
            lat_pc_q    <= 32'd0;
            lat_addr_q  <= 32'd0;
            epc_q       <= 32'd0;
            cause_q     <= CAUSE_NONE;
            bad_addr_q  <= 32'd0;
            ie_q        <= 1'b0;
            saved_ie_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (event_take) begin
                        lat_cause_q <= cause_d;
                        lat_pc_q    <= bus.pc;
                        lat_addr_q  <= bus.dataAddress;
                        state_q     <= SAVE;
                    end else if (eret_take) begin
                        // Pop the one-deep enable stack and refill it with 1, so
                        // a boot-time pair of erets is what turns interrupts on.
                        ie_q       <= saved_ie_q;
                        saved_ie_q <= 1'b1;
                    end
                end
                SAVE: begin
                    epc_q      <= lat_pc_q;
                    cause_q    <= lat_cause_q;
                    saved_ie_q <= ie_q;
                    ie_q       <= 1'b0;
                    if (lat_cause_q == CAUSE_DALIGN)      bad_addr_q <= lat_addr_q;
                    else if (lat_cause_q == CAUSE_IALIGN) bad_addr_q <= lat_pc_q;
                    state_q    <= VECTOR;
                end
                VECTOR: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.epc             = epc_q;
    assign bus.cause           = cause_q;
    assign bus.badAddress      = bad_addr_q;
    assign bus.interruptEnable = ie_q;

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 Parameter VECTOR_BASE, default 32'h0000_0100: base address of the exception vector table.
REQ-002 Parameter VECTOR_STRIDE, default 16: byte spacing between vector entries; power of two.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stageValid  input  1  instruction in the trigger stage is valid.
REQ-006 trigger  input  5  exception trigger bus from decode, packed MSB..LSB: break, system, unknown, instructionAlignment, dataAlignment.
REQ-007 irq  input  1  level-sensitive external interrupt request.
REQ-008 eret  input  1  valid return-from-exception instruction in stage.
REQ-009 pc  input  32  address of the instruction in stage.
REQ-010 dataAddress  input  32  effective data address of the instruction in stage.
REQ-011 flush  output  1  kill younger pipeline contents.
REQ-012 stall  output  1  freeze the fetch/decode front end.
REQ-013 redirect  output  1  load redirectAddress into the PC this cycle.
REQ-014 redirectAddress  output  32  new fetch address.
REQ-015 epc  output  32  saved exception PC.
REQ-016 cause  output  4  cause code of the last taken event.
REQ-017 badAddress  output  32  faulting address of the last alignment exception.
REQ-018 interruptEnable  output  1  global interrupt enable.

Function
REQ-019 The unit SHALL implement the FSM states IDLE, SAVE, and VECTOR.
REQ-020 Event taken in IDLE only: stageValid=1 and (trigger!=0 or (irq and interruptEnable)).
REQ-021 Cause codes: 1 interrupt, 2 break, 3 system, 4 unknown, 5 instructionAlignment, 6 dataAlignment; 0 reserved for reset.
REQ-022 Priority, highest first: instructionAlignment, unknown, dataAlignment, system, break, interrupt; only the highest asserted source SHALL be recorded.
REQ-023 Cycle N (IDLE, event): the winning cause and the pc/dataAddress values SHALL be latched internally; FSM -> SAVE; flush=1 combinationally in cycle N.
REQ-024 Cycle N+1 (SAVE): epc<=latched pc; cause<=latched cause; savedIe<=interruptEnable; interruptEnable<=0; flush=1; stall=1; FSM -> VECTOR.
REQ-025 badAddress SHALL update in SAVE only: cause 6 -> latched dataAddress; cause 5 -> latched pc; otherwise it holds its value.
REQ-026 Cycle N+2 (VECTOR): redirect=1; redirectAddress=VECTOR_BASE + cause*VECTOR_STRIDE (32-bit, wraps modulo 2^32); stall=1; FSM -> IDLE.
REQ-027 eret in IDLE with stageValid and no event: same cycle flush=1, redirect=1, redirectAddress=epc; next edge interruptEnable<=savedIe; FSM stays IDLE.
REQ-028 Simultaneous eret and event: the event SHALL win and eret SHALL be ignored.
REQ-029 In SAVE and VECTOR, trigger, irq, eret and stageValid SHALL be ignored (no nesting, no queuing).
REQ-030 Interrupt enable at reset SHALL be 0; it is set only via eret restoring savedIe=1.
REQ-031 A separate 1-bit ieSet input SHALL NOT exist; the core initialises savedIe via an eret sequence.
REQ-032 Outside the cases above: flush=0, stall=0, redirect=0, redirectAddress=0.

Reset
REQ-033 While reset_n=0, the unit SHALL force: FSM=IDLE; epc=0; cause=0; badAddress=0; interruptEnable=0; savedIe=0; all latches=0; flush=stall=redirect=0; redirectAddress=0.
REQ-034 Reset assertion mid-sequence (SAVE or VECTOR) SHALL abort the sequence immediately, with no redirect; state SHALL not be partially updated after release.
REQ-035 The first event SHALL be accepted on the first rising edge after reset_n deasserts.

Verification
REQ-036 Triggers system+break together, pc=0x2000 -> flush at N, cause=3 and epc=0x2000 after N+1, redirect at N+2 to 0x130.
REQ-037 dataAlignment only, dataAddress=0x1003, pc=0x0400 -> badAddress=0x1003, cause=6, redirectAddress=0x160.
REQ-038 irq=1 with interruptEnable=0 -> no flush and no state change; after savedIe=1 and eret: irq -> cause=1, vector 0x110, interruptEnable=0.
REQ-039 eret and unknown asserted together, pc=0x3000 -> cause=4, epc=0x3000, redirectAddress=0x140; interruptEnable unchanged by the eret.
REQ-040 New triggers during SAVE and during VECTOR -> ignored; exactly one redirect; cause retains the first value.
REQ-041 reset_n low in the SAVE cycle -> no redirect, all outputs 0, next event handled normally.
